ram_reader: RTL and testbench

Sequential read-out engine for the 32x4 synchronous RAM (`ram32x4`), the reading counterpart to the switch-driven writer front end. On a start pulse it walks a contiguous, wrapping address range and emits each word as an address/data pair on a valid/ready stream. Downstream display or serial logic consumes that stream. It never writes: the RAM write-enable it drives is tied low.

---
 rtl/ram_reader_pkg.sv | 24 ++
 rtl/ram32x4.sv | 29 ++
 rtl/ram_reader.sv | 122 ++++++++++++
 tb/tb_ram_reader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Shared constants and types for the ram_reader read-out engine.
//   ADDR_W / DATA_W / DEPTH : geometry of the 32x4 RAM being scanned
//   state_t                 : scan FSM states
//   addr_t / word_t         : RAM address and word types
//   cnt_t                   : word-count type (one bit wider than an address)
package ram_reader_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage : ram_reader_pkg

// File: rtl/ram32x4.sv
// 32x4 synchronous RAM: the address is registered on the rising edge and
// q shows the word at the registered address; writes when wren is high.
//   address : word address
//   clock   : clock
//   data    : write data
//   wren    : write enable
//   q       : read data, valid one clock after the address is sampled
module ram32x4 (
  input  logic [4:0] address,
  input  logic       clock,
  input  logic [3:0] data,
  input  logic       wren,
  output logic [3:0] q
);

  logic [3:0] mem [32];
  logic [4:0] addr_q;

  // Write port and address register.
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
    addr_q <= address;
  end

  assign q = mem[addr_q];

endmodule : ram32x4

// File: rtl/ram_reader.sv
// Sequential read-out engine for the 32x4 synchronous RAM. A start pulse
// in IDLE launches a scan of `count` words (clamped to DEPTH) beginning at
// `first_addr` and wrapping modulo DEPTH; each word is presented as an
// address/data pair on a valid/ready stream.
//   clock, reset       : clock and asynchronous active-high reset
//   start              : begin a scan (ignored unless idle)
//   first_addr, count  : scan range, sampled with start
//   ram_address        : RAM address, always the current-address register
//   ram_wren           : RAM write enable, tied low
//   ram_q              : RAM read data
//   out_valid/out_ready: output stream handshake
//   out_addr, out_data : presented word and its address
//   busy               : high whenever not idle
//   done               : one-cycle pulse when a scan finishes
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ram_reader_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_reader_pkg::DATA_W,
  parameter int unsigned DEPTH  = ram_reader_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CW-1:0]     remaining;
  logic [CW-1:0]     count_clamped;

  // Requests larger than the RAM read every word exactly once.
  always_comb begin
    count_clamped = count;
    if (count > CW'(DEPTH)) begin
      count_clamped = CW'(DEPTH);
    end
  end

  // The engine only reads; the RAM sees the current address directly.
  assign ram_address = cur_addr;
  assign ram_wren    = 1'b0;

  // Scan FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count_clamped != '0) begin
              cur_addr  <= first_addr;
              remaining <= count_clamped;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              // Empty scan: finish immediately without emitting anything.
              done <= 1'b1;
            end
          end
        end

        // Address is held for the whole cycle; the RAM registers it at the
        // closing edge and its data is available in CAPTURE.
        READ: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          out_data  <= ram_q;
          out_addr  <= cur_addr;
          out_valid <= 1'b1;
          state     <= HOLD;
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              // Natural ADDR_W-bit overflow wraps modulo DEPTH.
              cur_addr <= cur_addr + ADDR_W'(1);
              state    <= READ;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : ram_reader

// File: tb/tb_ram_reader.sv
module tb_ram_reader;
  import ram_reader_pkg::*;

  localparam int TD = int'(DEPTH);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] first_addr = '0;
  logic [5:0] count = '0;
  logic       out_ready = 1'b0;
  logic [4:0] ram_address;
  logic       ram_wren;
  logic [3:0] ram_q;
  logic       out_valid;
  logic [4:0] out_addr;
  logic [3:0] out_data;
  logic       busy;
  logic       done;

  logic       preload = 1'b0;
  logic [4:0] pl_addr = '0;
  logic [3:0] pl_data = '0;
  logic       pl_wren = 1'b0;
  logic [4:0] mux_addr;
  logic       mux_wren;

  assign mux_addr = preload ? pl_addr : ram_address;
  assign mux_wren = preload ? pl_wren : ram_wren;

  ram32x4 u_ram (
    .address(mux_addr),
    .clock  (clock),
    .data   (pl_data),
    .wren   (mux_wren),
    .q      (ram_q)
  );

  ram_reader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .ram_address(ram_address),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pre_val(input int a);
    case (a)
      2:       return 4'hA;
      3:       return 4'h3;
      4:       return 4'hF;
      5:       return 4'h0;
      default: return 4'(a * 3 + 1);
    endcase
  endfunction

  // Behavioural model: list of words a scan must deliver, plus the rule that
  // a word becomes valid 3 cycles after start or after the previous acceptance.
  int m_mem [32];
  int m_qa [$];
  int m_qd [$];
  bit m_busy = 0;
  bit m_done = 0;
  int m_vcyc = 0;
  bit mon_en = 0;
  bit prev_valid = 0;

  int acc_addr [$];
  int acc_data [$];
  int acc_cyc [$];
  int vrise_cyc [$];
  int done_cyc [$];
  int start_cyc = 0;

  always @(negedge clock) begin
    bit exp_valid;
    int n;
    int a;
    if (reset) begin
      m_busy = 0;
      m_done = 0;
      m_qa.delete();
      m_qd.delete();
      prev_valid = 0;
    end else if (mon_en) begin
      exp_valid = m_busy && (cyc >= m_vcyc);
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("ram_wren", int'(ram_wren), 0);
      chk("out_valid", int'(out_valid), int'(exp_valid));
      if (out_valid && exp_valid) begin
        chk("out_addr", int'(out_addr), m_qa[0]);
        chk("out_data", int'(out_data), m_qd[0]);
      end
      if (out_valid && !prev_valid) vrise_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      prev_valid = out_valid;

      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          n = (int'(count) > TD) ? TD : int'(count);
          if (n == 0) begin
            m_done = 1;
          end else begin
            for (int i = 0; i < n; i++) begin
              a = (int'(first_addr) + i) % TD;
              m_qa.push_back(a);
              m_qd.push_back(m_mem[a]);
            end
            m_busy = 1;
            m_vcyc = cyc + 3;
          end
        end
      end else if (exp_valid && out_ready) begin
        acc_addr.push_back(int'(out_addr));
        acc_data.push_back(int'(out_data));
        acc_cyc.push_back(cyc);
        void'(m_qa.pop_front());
        void'(m_qd.pop_front());
        if (m_qa.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_vcyc = cyc + 3;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    acc_data.delete();
    acc_cyc.delete();
    vrise_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic do_start(input int fa, input int cnt);
    first_addr = 5'(fa);
    count      = 6'(cnt);
    start      = 1'b1;
    start_cyc  = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!m_busy) break;
      tick();
    end
    chk("scan_timeout", int'(m_busy), 0);
    tick();
  endtask

  task automatic wait_acc(input int want, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (acc_addr.size() >= want) break;
      tick();
    end
    chk("acc_timeout", int'(acc_addr.size() >= want), 1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_addr"}, int'(out_addr), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ram_address"}, int'(ram_address), 0);
    chk({tag, "_ram_wren"}, int'(ram_wren), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected completion");
    $fatal(1);
  end

  initial begin
    // Preload the RAM with the reader held in reset.
    preload = 1'b1;
    for (int a = 0; a < 32; a++) begin
      pl_addr  = 5'(a);
      pl_data  = pre_val(a);
      pl_wren  = 1'b1;
      m_mem[a] = int'(pre_val(a));
      tick();
    end
    pl_wren = 1'b0;
    preload = 1'b0;
    tick();
    chk_cleared("reset");

    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
    tick();
    chk_cleared("idle");

    // Basic scan.
    clear_logs();
    out_ready = 1'b1;
    do_start(2, 4);
    wait_idle(100);
    chk("basic_words", acc_addr.size(), 4);
    chk("basic_a0", acc_addr[0], 2);  chk("basic_d0", acc_data[0], 10);
    chk("basic_a1", acc_addr[1], 3);  chk("basic_d1", acc_data[1], 3);
    chk("basic_a2", acc_addr[2], 4);  chk("basic_d2", acc_data[2], 15);
    chk("basic_a3", acc_addr[3], 5);  chk("basic_d3", acc_data[3], 0);
    chk("basic_latency", vrise_cyc[0] - start_cyc, 3);
    chk("basic_spacing1", vrise_cyc[1] - vrise_cyc[0], 3);
    chk("basic_spacing3", vrise_cyc[3] - vrise_cyc[2], 3);
    chk("basic_done_count", done_cyc.size(), 1);
    chk("basic_done_time", done_cyc[0] - acc_cyc[3], 1);

    // Wrap around the top of the address space.
    clear_logs();
    do_start(30, 4);
    wait_idle(100);
    chk("wrap_words", acc_addr.size(), 4);
    chk("wrap_a0", acc_addr[0], 30); chk("wrap_d0", acc_data[0], 11);
    chk("wrap_a1", acc_addr[1], 31); chk("wrap_d1", acc_data[1], 14);
    chk("wrap_a2", acc_addr[2], 0);  chk("wrap_d2", acc_data[2], 1);
    chk("wrap_a3", acc_addr[3], 1);  chk("wrap_d3", acc_data[3], 4);

    // Oversized count clamps to the whole RAM.
    clear_logs();
    do_start(7, 40);
    wait_idle(300);
    chk("clamp_words", acc_addr.size(), 32);
    chk("clamp_a24", acc_addr[24], 31);
    chk("clamp_a25", acc_addr[25], 0);

    // Backpressure on word 2 plus an ignored start while busy.
    clear_logs();
    out_ready = 1'b1;
    do_start(10, 4);
    wait_acc(1, 20);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) break;
      tick();
    end
    first_addr = 5'd9;
    count      = 6'd2;
    start      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_addr", int'(out_addr), 11);
      chk("bp_data", int'(out_data), 2);
      chk("bp_ram_address", int'(ram_address), 11);
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    wait_idle(100);
    chk("bp_words", acc_addr.size(), 4);
    chk("bp_a1", acc_addr[1], 11);
    chk("bp_a3", acc_addr[3], 13);
    chk("bp_done_count", done_cyc.size(), 1);

    // Zero count finishes without emitting.
    clear_logs();
    do_start(5, 0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    tick();
    chk("zero_done_clear", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      chk("zero_no_valid", int'(out_valid), 0);
      chk("zero_idle", int'(busy), 0);
      tick();
    end
    chk("zero_words", vrise_cyc.size(), 0);

    // Reset in the CAPTURE cycle of word 3, then a one-word scan.
    clear_logs();
    do_start(20, 5);
    wait_acc(2, 30);
    tick();
    chk("mid_busy", int'(busy), 1);
    chk("mid_addr_before", int'(out_addr), 21);
    #2;
    reset = 1'b1;
    #1;
    chk_cleared("midreset");
    tick();
    reset = 1'b0;
    tick();
    clear_logs();
    do_start(0, 1);
    wait_idle(50);
    chk("post_words", acc_addr.size(), 1);
    chk("post_a0", acc_addr[0], 0);
    chk("post_d0", acc_data[0], 1);
    chk("post_done_count", done_cyc.size(), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule : tb_ram_reader
